sync_caller: RTL and testbench

- Initiator side of the team's sync valid/ready call protocol, as exposed by generated modules such as algorithm_gcd (in_valid/in_ready in, out_valid/out_ready out).
- Accepts one operand pair at a time from an upstream request stream, holds it stable while issuing the call, then waits for the callee's result.
- Returns the result, or a timeout flag, on a downstream response stream.
- Replaces hand-written one-shot bench stimulus; used wherever RTL must call a generated function block.

---
 rtl/sync_caller_pkg.sv | 20 ++
 rtl/sync_timer.sv | 34 +++
 rtl/sync_caller.sv | 151 +++++++++++++++
 tb/tb_sync_caller.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_caller_pkg.sv
// Shared types and helpers for the sync valid/ready call initiator.
package sync_caller_pkg;

    // Caller states; the encoding is fixed so that waveforms and checkers
    // can decode the state register directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Timer width for a given limit: enough bits to hold LIMIT, never zero.
    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_timer.sv
// Cycle counter for the WAIT state. It counts while enabled, is cleared on
// request, and flags the cycle in which the count reaches LIMIT-1.
// LIMIT=0 means the timer never expires.
module sync_timer
    import sync_caller_pkg::*;
#(
    parameter int LIMIT = 255,
    parameter int W     = timer_width(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] r_count;

    // Count up while enabled; a clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (LIMIT != 0) && (r_count == LAST);

endmodule

// File: rtl/sync_caller.sv
// Initiator for the sync valid/ready call protocol. Takes one operand pair
// from the request stream, issues it to the callee, waits for the result
// (or a timeout) and returns it on the response stream.
//
// Handshake rule for every stream here: a transfer happens on a rising edge
// where valid and ready are both high; a valid side keeps its data stable
// until that edge. All outputs come straight from registers, so there is no
// combinational path from any input to any output.
module sync_caller
    import sync_caller_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [N-1:0]    req_a,
    input  logic [N-1:0]    req_b,
    output logic            call_in_valid,
    input  logic            call_in_ready,
    output logic [N-1:0]    call_in0,
    output logic [N-1:0]    call_in1,
    input  logic            call_out_valid,
    output logic            call_out_ready,
    input  logic [N-1:0]    call_out0,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_data,
    output logic            rsp_timeout,
    output logic            busy,
    output logic [CNTW-1:0] done_count
);

    state_t          r_state;
    logic            r_req_ready;
    logic            r_call_in_valid;
    logic            r_call_out_ready;
    logic            r_rsp_valid;
    logic            r_rsp_timeout;
    logic            r_busy;
    logic [N-1:0]    r_call_in0;
    logic [N-1:0]    r_call_in1;
    logic [N-1:0]    r_rsp_data;
    logic [CNTW-1:0] r_done_count;

    logic            w_issue_hs;
    logic            w_timer_en;
    logic            w_expire;

    assign w_issue_hs = (r_state == ST_ISSUE) && call_in_ready;
    assign w_timer_en = (r_state == ST_WAIT);

    sync_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_issue_hs),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    // Call sequencer. Every handshake flag is registered alongside the state
    // change that implies it. req_ready is low while reset is held and comes
    // up on the first edge after release, so nothing is accepted early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_req_ready      <= 1'b0;
            r_call_in_valid  <= 1'b0;
            r_call_out_ready <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_timeout    <= 1'b0;
            r_busy           <= 1'b0;
            r_call_in0       <= '0;
            r_call_in1       <= '0;
            r_rsp_data       <= '0;
            r_done_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (r_req_ready && req_valid) begin
                        r_call_in0      <= req_a;
                        r_call_in1      <= req_b;
                        r_req_ready     <= 1'b0;
                        r_call_in_valid <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Operands stay put until the callee takes them; the
                    // timeout does not run here.
                    if (call_in_ready) begin
                        r_call_in_valid  <= 1'b0;
                        r_call_out_ready <= 1'b1;
                        r_state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result arriving on the expiry cycle beats the timeout.
                    if (call_out_valid) begin
                        r_rsp_data       <= call_out0;
                        r_rsp_timeout    <= 1'b0;
                        r_call_out_ready <= 1'b0;
                        r_rsp_valid      <= 1'b1;
                        r_state          <= ST_RESP;
                    end else if (w_expire) begin
                        r_rsp_data       <= '0;
                        r_rsp_timeout    <= 1'b1;
                        r_call_out_ready <= 1'b0;
                        r_rsp_valid      <= 1'b1;
                        r_state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Response held under backpressure; only completed calls
                    // are counted, timeouts are not.
                    if (rsp_ready) begin
                        if (!r_rsp_timeout) begin
                            r_done_count <= r_done_count + 1'b1;
                        end
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign call_in_valid  = r_call_in_valid;
    assign call_in0       = r_call_in0;
    assign call_in1       = r_call_in1;
    assign call_out_ready = r_call_out_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_timeout    = r_rsp_timeout;
    assign busy           = r_busy;
    assign done_count     = r_done_count;

endmodule

// File: tb/tb_sync_caller.sv
// Bench for sync_caller: a behavioural GCD callee with programmable
// in_ready stall, result latency and silence, driven from a vector table
// plus hand-written reset sequences.
module tb_sync_caller;

    localparam int N       = 8;
    localparam int TIMEOUT = 8;
    localparam int CNTW    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [N-1:0]    req_a = '0;
    logic [N-1:0]    req_b = '0;
    logic            call_in_valid;
    logic            call_in_ready;
    logic [N-1:0]    call_in0;
    logic [N-1:0]    call_in1;
    logic            call_out_valid;
    logic            call_out_ready;
    logic [N-1:0]    call_out0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [N-1:0]    rsp_data;
    logic            rsp_timeout;
    logic            busy;
    logic [CNTW-1:0] done_count;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1, "watchdog");
    end

    sync_caller #(
        .N       (N),
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .call_in_valid  (call_in_valid),
        .call_in_ready  (call_in_ready),
        .call_in0       (call_in0),
        .call_in1       (call_in1),
        .call_out_valid (call_out_valid),
        .call_out_ready (call_out_ready),
        .call_out0      (call_out0),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .done_count     (done_count)
    );

    // ---------------- behavioural callee ----------------
    function automatic logic [N-1:0] gcd(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    logic         c_rst = 1'b0;
    logic         c_busy;
    int           c_seen;
    int           c_cnt;
    logic [N-1:0] c_res;
    int           cfg_stall = 0;
    int           cfg_lat = 0;
    logic         cfg_silent = 1'b0;

    assign call_in_ready  = !c_busy && (c_seen >= cfg_stall);
    assign call_out_valid = c_busy && !cfg_silent && (c_cnt >= cfg_lat);
    assign call_out0      = c_res;

    always @(posedge clk or posedge rst or posedge c_rst) begin
        if (rst || c_rst) begin
            c_busy <= 1'b0;
            c_seen <= 0;
            c_cnt  <= 0;
            c_res  <= '0;
        end else if (!c_busy) begin
            if (call_in_valid && call_in_ready) begin
                c_busy <= 1'b1;
                c_cnt  <= 0;
                c_seen <= 0;
                c_res  <= gcd(call_in0, call_in1);
            end else if (call_in_valid) begin
                c_seen <= c_seen + 1;
            end
        end else begin
            if (call_out_valid && call_out_ready) begin
                c_busy <= 1'b0;
            end else begin
                c_cnt <= c_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int              n_checks = 0;
    int              n_pass = 0;
    logic [N-1:0]    exp_q[$];
    logic [CNTW-1:0] exp_done = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           stall;
        int           lat;
        int           hold;
        logic         silent;
        logic         keep;
        logic [N-1:0] exp_data;
        logic         exp_to;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                       input int lat, input int hold, input logic silent, input logic keep,
                       input logic [N-1:0] exp_data, input logic exp_to);
        vec_t v;
        v.a = a; v.b = b; v.stall = stall; v.lat = lat; v.hold = hold;
        v.silent = silent; v.keep = keep; v.exp_data = exp_data; v.exp_to = exp_to;
        vq.push_back(v);
    endtask

    // One full call: request handshake, issue/wait, response with optional
    // backpressure. With keep set, req_valid stays high carrying nxt.
    task automatic run_txn(input vec_t v, input vec_t nxt);
        logic         hs;
        int           cyc;
        int           issue_cycles;
        int           exp_lat;
        logic         stable_ok;
        logic         rdy_ok;
        logic         held_ok;
        logic [N-1:0] d0;
        logic [N-1:0] exp_d;

        cfg_stall  = v.stall;
        cfg_lat    = v.lat;
        cfg_silent = v.silent;
        req_valid  = 1'b1;
        req_a      = v.a;
        req_b      = v.b;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = req_ready;
            step();
        end
        if (!hs) begin
            check("req_handshake", 0, 1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(v.exp_data);
        if (v.keep) begin
            req_a = nxt.a;
            req_b = nxt.b;
        end else begin
            req_valid = 1'b0;
        end
        check("issue_valid", call_in_valid, 1);
        check("issue_in0", call_in0, v.a);
        check("issue_in1", call_in1, v.b);
        check("busy_set", busy, 1);

        cyc = 1;
        issue_cycles = 0;
        stable_ok = 1'b1;
        rdy_ok = 1'b1;
        while (!rsp_valid && cyc < 400) begin
            if (call_in_valid) begin
                issue_cycles++;
                if (call_in0 !== v.a || call_in1 !== v.b) stable_ok = 1'b0;
            end
            if (req_ready) rdy_ok = 1'b0;
            step();
            cyc++;
        end
        exp_lat = v.silent ? (2 + v.stall + TIMEOUT) : (3 + v.stall + v.lat);
        check("rsp_latency", cyc, exp_lat);
        check("issue_cycles", issue_cycles, v.stall + 1);
        check("issue_stable", stable_ok, 1);
        check("req_ready_low", rdy_ok, 1);
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("rsp_data", rsp_data, v.exp_to ? 0 : exp_d);
        check("rsp_timeout", rsp_timeout, v.exp_to);

        d0 = rsp_data;
        held_ok = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            step();
            if (!rsp_valid || rsp_data !== d0 || done_count !== exp_done || req_ready)
                held_ok = 1'b0;
        end
        if (v.hold > 0) check("rsp_hold", held_ok, 1);

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (!v.exp_to) exp_done = exp_done + 1'b1;
        check("done_count", done_count, exp_done);
        check("busy_clear", busy, 0);
        check("rsp_valid_clear", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);

        if (v.silent) begin
            // The callee still holds a pending call after a timeout; reset it.
            cfg_silent = 1'b0;
            c_rst = 1'b1;
            #1;
            c_rst = 1'b0;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic hs;
        logic spurious;

        // a, b, stall, lat, hold, silent, keep, exp_data, exp_to
        add(8'd21,  8'd35,  0, 2, 0,  1'b0, 1'b0, 8'd7,  1'b0);
        add(8'd12,  8'd18,  0, 1, 0,  1'b0, 1'b1, 8'd6,  1'b0);
        add(8'd17,  8'd5,   0, 0, 0,  1'b0, 1'b0, 8'd1,  1'b0);
        add(8'd48,  8'd36,  5, 6, 0,  1'b0, 1'b0, 8'd12, 1'b0);
        add(8'd21,  8'd35,  0, 1, 10, 1'b0, 1'b0, 8'd7,  1'b0);
        add(8'd99,  8'd33,  0, 0, 0,  1'b1, 1'b0, 8'd0,  1'b1);
        add(8'd40,  8'd24,  0, 7, 0,  1'b0, 1'b0, 8'd8,  1'b0);
        add(8'd255, 8'd85,  0, 3, 2,  1'b0, 1'b0, 8'd85, 1'b0);
        add(8'd0,   8'd9,   0, 0, 0,  1'b0, 1'b0, 8'd9,  1'b0);
        add(8'd13,  8'd13,  0, 2, 0,  1'b0, 1'b0, 8'd13, 1'b0);
        add(8'd200, 8'd120, 0, 4, 0,  1'b0, 1'b0, 8'd40, 1'b0);
        add(8'd77,  8'd0,   2, 0, 3,  1'b1, 1'b0, 8'd0,  1'b1);

        // Reset state while rst is held.
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done_count", done_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_req_ready", req_ready, 1);

        for (int i = 0; i < vq.size(); i++) begin
            run_txn(vq[i], (i + 1 < vq.size()) ? vq[i + 1] : vq[i]);
        end

        // Asynchronous reset in the middle of WAIT.
        cfg_silent = 1'b1;
        cfg_stall  = 0;
        cfg_lat    = 0;
        req_valid  = 1'b1;
        req_a      = 8'd30;
        req_b      = 8'd45;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = req_ready;
            step();
        end
        req_valid = 1'b0;
        step();
        step();
        step();
        check("mid_wait_out_ready", call_out_ready, 1);
        check("mid_wait_count_nonzero", done_count != 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req_ready", req_ready, 0);
        check("arst_call_in_valid", call_in_valid, 0);
        check("arst_call_out_ready", call_out_ready, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_call_in0", call_in0, 0);
        check("arst_call_in1", call_in1, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_rsp_timeout", rsp_timeout, 0);
        check("arst_done_count", done_count, 0);
        exp_done = '0;
        exp_q.delete();
        cfg_silent = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid || busy) spurious = 1'b1;
        end
        check("arst_no_spurious_rsp", spurious, 0);
        check("arst_req_ready_after", req_ready, 1);

        // Recovery: a normal call after the abort.
        run_txn(vq[0], vq[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
